// File: rtl/mmss_timer.sv
// -----------------------------------------------------------------------------
// mmss_timer
//   Seconds timer stage ahead of the MM:SS seven-segment display stage.
//   Counts elapsed seconds up from 0, or down from a switch-loaded preset,
//   under push-button control. The free-running clock is divided to a 1 Hz
//   count tick by an internal prescaler.
//
// Parameters
//   CLK_HZ    clock cycles per count tick (min 2)
//   MAX_SECS  up-count terminal value and preset cap (1..511)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   btn_start  in   1  start/pause button level (asynchronous to clk)
//   btn_clear  in   1  clear button level (asynchronous to clk)
//   mode_down  in   1  0 = count up, 1 = count down (sampled in IDLE)
//   load_val   in   9  count-down preset in seconds (sampled in IDLE)
//   seconds    out  9  current count, binary seconds, registered
//   running    out  1  high while in RUN
//   done       out  1  high while in DONE
//   flash      out  1  1 Hz alarm blink while in DONE
//
// Build option
//   MMSS_TIMER_FLASH_EN : when defined, flash blinks at 1 Hz in DONE.
//                         When undefined, flash is a constant 0.
//
// The FSM state is held in state_q (IDLE/RUN/PAUSE/DONE); running and done
// are registered decodes of it and can be used to observe the state.
// -----------------------------------------------------------------------------
module mmss_timer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int MAX_SECS = 511
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       mode_down,
  input  logic [8:0] load_val,
  output logic [8:0] seconds,
  output logic       running,
  output logic       done,
  output logic       flash
);

  localparam int              PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [8:0]      MAX_VAL  = 9'(MAX_SECS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    start_sync_q, clear_sync_q;
  logic          start_prev_q, clear_prev_q;
  logic          start_ev, clear_ev;
  logic          mode_q, mode_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [8:0]    secs_q, secs_d;
  logic [8:0]    preset;
  logic          tick;
  logic          running_q, done_q;

`ifdef MMSS_TIMER_FLASH_EN
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2 - 1);
  logic flash_q, flash_d;
`endif

  // One-cycle events on the synchronised rising edge of each button.
  assign start_ev = start_sync_q[1] & ~start_prev_q;
  assign clear_ev = clear_sync_q[1] & ~clear_prev_q;

  always_comb begin
    preset  = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    tick    = (state_q == S_RUN) && (pre_q == PRE_LAST);
    state_d = state_q;
    secs_d  = secs_q;
    mode_d  = mode_q;
    pre_d   = pre_q;

    case (state_q)
      S_IDLE: begin
        // Preset is reloaded every cycle so switch changes show immediately.
        mode_d = mode_down;
        secs_d = mode_down ? preset : 9'd0;
        pre_d  = '0;
        if (start_ev) begin
          state_d = (mode_down && (preset == 9'd0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          if (mode_q) begin
            if (secs_q != 9'd0) begin
              secs_d = secs_q - 9'd1;
              if (secs_q == 9'd1) state_d = S_DONE;
            end
          end else if (secs_q < MAX_VAL) begin
            secs_d = secs_q + 9'd1;
            if (secs_q == MAX_VAL - 9'd1) state_d = S_DONE;
          end
        end
        // A tick coinciding with pause is kept; reaching terminal wins over pause.
        if (start_ev && (state_d == S_RUN)) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        // pre_q holds so the partial second resumes where it stopped.
        if (start_ev) state_d = S_RUN;
      end
      default: begin
        // DONE: count value frozen; prescaler keeps running to pace the blink.
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      end
    endcase

    // Clear beats start and discards any same-cycle tick.
    if (clear_ev) begin
      state_d = S_IDLE;
      secs_d  = secs_q;
    end

`ifdef MMSS_TIMER_FLASH_EN
    flash_d = 1'b0;
    if ((state_q == S_DONE) && (state_d == S_DONE)) begin
      flash_d = ((pre_q == PRE_HALF) || (pre_q == PRE_LAST)) ? ~flash_q : flash_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q <= 2'b00;
      clear_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      pre_q        <= '0;
      secs_q       <= 9'd0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
`ifdef MMSS_TIMER_FLASH_EN
      flash_q      <= 1'b0;
`endif
    end else begin
      start_sync_q <= {start_sync_q[0], btn_start};
      clear_sync_q <= {clear_sync_q[0], btn_clear};
      start_prev_q <= start_sync_q[1];
      clear_prev_q <= clear_sync_q[1];
      state_q      <= state_d;
      mode_q       <= mode_d;
      pre_q        <= pre_d;
      secs_q       <= secs_d;
      running_q    <= (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
`ifdef MMSS_TIMER_FLASH_EN
      flash_q      <= flash_d;
`endif
    end
  end

  assign seconds = secs_q;
  assign running = running_q;
  assign done    = done_q;
`ifdef MMSS_TIMER_FLASH_EN
  assign flash   = flash_q;
`else
  assign flash   = 1'b0;
`endif

endmodule

// File: tb/tb_mmss_timer.sv
// -----------------------------------------------------------------------------
// tb_mmss_timer
//   Drives two timers (MAX_SECS 511 and 5, CLK_HZ 4) from shared buttons and
//   switches, and compares every output after every clock edge against a
//   reference model that derives the count from elapsed running time.
// -----------------------------------------------------------------------------
module tb_mmss_timer;

  localparam int CLK = 4;
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  // clock / reset / stimulus
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       mode_down = 1'b0;
  logic [8:0] load_val = 9'd0;

  logic [8:0] sec_a, sec_b;
  logic       run_a, run_b, done_a, done_b, fl_a, fl_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmss_timer #(.CLK_HZ(CLK), .MAX_SECS(511)) dut_a (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
    .mode_down(mode_down), .load_val(load_val),
    .seconds(sec_a), .running(run_a), .done(done_a), .flash(fl_a)
  );

  mmss_timer #(.CLK_HZ(CLK), .MAX_SECS(5)) dut_b (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
    .mode_down(mode_down), .load_val(load_val),
    .seconds(sec_b), .running(run_b), .done(done_b), .flash(fl_b)
  );

  // reference model: one entry per DUT
  int maxs [2] = '{511, 5};
  int m_st [2];
  int m_sec[2];
  int m_el [2];   // edges spent counting in RUN since start
  int m_pre[2];   // latched preset
  int m_dc [2];   // edges spent in DONE
  bit m_down[2];
  int edge_n = 0;
  int start_due[$];
  int clear_due[$];
  bit prev_s, prev_c;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_flash(input int i);
    int t;
    t = 0;
`ifdef MMSS_TIMER_FLASH_EN
    if (m_st[i] == ST_DONE) begin
      for (int k = 0; k < m_dc[i]; k++) begin
        if ((k % CLK == CLK / 2 - 1) || (k % CLK == CLK - 1)) t = t ^ 1;
      end
    end
`endif
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = ST_IDLE; m_sec[i] = 0; m_el[i] = 0;
      m_pre[i] = 0; m_dc[i] = 0; m_down[i] = 1'b0;
    end
    start_due.delete();
    clear_due.delete();
    prev_s = 1'b0;
    prev_c = 1'b0;
  endtask

  // Applied once per rising edge with the input values present at that edge.
  task automatic model_edge();
    bit s_ev, c_ev;
    int p;
    s_ev = 1'b0;
    c_ev = 1'b0;
    edge_n++;
    if (start_due.size() != 0 && start_due[0] == edge_n) begin
      s_ev = 1'b1; void'(start_due.pop_front());
    end
    if (clear_due.size() != 0 && clear_due[0] == edge_n) begin
      c_ev = 1'b1; void'(clear_due.pop_front());
    end
    // A press first seen at this edge acts on the third edge counting this one.
    if (btn_start && !prev_s) start_due.push_back(edge_n + 2);
    if (btn_clear && !prev_c) clear_due.push_back(edge_n + 2);
    prev_s = btn_start;
    prev_c = btn_clear;

    for (int i = 0; i < 2; i++) begin
      if (c_ev) begin
        m_st[i] = ST_IDLE;
      end else begin
        case (m_st[i])
          ST_IDLE: begin
            p = mode_down ? imin(int'(load_val), maxs[i]) : 0;
            m_sec[i] = p;
            if (s_ev) begin
              m_down[i] = mode_down;
              m_pre[i]  = p;
              m_el[i]   = 0;
              m_dc[i]   = 0;
              m_st[i]   = (mode_down && p == 0) ? ST_DONE : ST_RUN;
            end
          end
          ST_RUN: begin
            m_el[i]++;
            if (m_down[i]) m_sec[i] = m_pre[i] - imin(m_el[i] / CLK, m_pre[i]);
            else           m_sec[i] = imin(m_el[i] / CLK, maxs[i]);
            if ((m_down[i] && m_sec[i] == 0) || (!m_down[i] && m_sec[i] == maxs[i])) begin
              m_st[i] = ST_DONE;
              m_dc[i] = 0;
            end else if (s_ev) begin
              m_st[i] = ST_PAUSE;
            end
          end
          ST_PAUSE: if (s_ev) m_st[i] = ST_RUN;
          default:  m_dc[i]++;
        endcase
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("sec_a",   32'(sec_a),  m_sec[0]);
    check("run_a",   32'(run_a),  32'(m_st[0] == ST_RUN));
    check("done_a",  32'(done_a), 32'(m_st[0] == ST_DONE));
    check("flash_a", 32'(fl_a),   exp_flash(0));
    check("sec_b",   32'(sec_b),  m_sec[1]);
    check("run_b",   32'(run_b),  32'(m_st[1] == ST_RUN));
    check("done_b",  32'(done_b), 32'(m_st[1] == ST_DONE));
    check("flash_b", 32'(fl_b),   exp_flash(1));
  endtask

  // driver tasks: each leaves time at 1 unit after a rising edge
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  endtask

  task automatic press_start(input int hold);
    btn_start = 1'b1; tick_n(hold);
    btn_start = 1'b0; tick_n(1);
  endtask

  task automatic press_clear(input int hold);
    btn_clear = 1'b1; tick_n(hold);
    btn_clear = 1'b0; tick_n(1);
  endtask

  // Asserts rst between edges and checks the outputs cleared before any edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int act;

  initial begin
    // async reset with no clock edge yet
    do_reset();
    tick_n(3);

    // up count, pause around seconds 2, resume through the partial second
    mode_down = 1'b0;
    press_start(2);
    tick_n(9);
    tick_n($urandom_range(0, 3));
    press_start(40);
    tick_n(5);
    press_start(2);
    tick_n(24);          // MAX 5 timer reaches DONE here; start then ignored
    press_start(1);
    tick_n(6);
    press_clear(1);
    tick_n(3);

    // down count from 3, then start ignored in DONE
    mode_down = 1'b1;
    load_val  = 9'd3;
    tick_n(2);
    press_start(1);
    tick_n(18);
    press_start(2);
    tick_n(8);
    press_clear(2);
    tick_n(3);

    // oversize preset is capped at MAX_SECS
    load_val = 9'd500;
    tick_n(3);
    press_start(1);
    tick_n(10);
    press_clear(1);
    tick_n(3);

    // start and clear together while running: clear wins
    mode_down = 1'b0;
    press_start(1);
    tick_n(6);
    btn_start = 1'b1; btn_clear = 1'b1;
    tick_n(2);
    btn_start = 1'b0; btn_clear = 1'b0;
    tick_n(4);

    // zero preset in down mode goes straight to DONE (blink if built in)
    mode_down = 1'b1;
    load_val  = 9'd0;
    tick_n(2);
    press_start(1);
    tick_n(14);
    press_clear(1);
    tick_n(3);

    // randomized button/switch activity
    for (int it = 0; it < 120; it++) begin
      act = $urandom_range(0, 9);
      if (act <= 3) begin
        press_start($urandom_range(1, 3));
      end else if (act == 4) begin
        press_clear($urandom_range(1, 2));
      end else if (act == 5) begin
        mode_down = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) load_val = 9'($urandom_range(0, 8));
        else                           load_val = 9'($urandom_range(0, 511));
        tick_n(1);
      end else begin
        tick_n($urandom_range(1, 24));
      end
    end

    // reset mid-operation loses the count
    btn_start = 1'b0; btn_clear = 1'b0;
    mode_down = 1'b0;
    tick_n(4);
    press_start(1);
    tick_n(10);
    do_reset();
    tick_n(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
